// File: rtl/timer_control_if.sv
// Load/observe link between timer_control and the countdown stage.
// The master drives value/put; the countdown slave returns count.
interface timer_control_if #(
    parameter int W = 8
);
    logic [W-1:0] value;
    logic         put;
    logic [W-1:0] count;

    modport master (
        output value,
        output put,
        input  count
    );

    modport slave (
        input  value,
        input  put,
        output count
    );
endinterface

// File: rtl/timer_control.sv
// One-shot/periodic control stage around the countdown timer.
// Define TIMER_CONTROL_OVERRUN_EN to add the saturating overrun counter.
module timer_control #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] reload,
    input  logic         periodic,
    input  logic         start,
    input  logic         stop,
    input  logic         ack,
    timer_control_if.master cd,
    output logic         running,
    output logic         expired,
`ifdef TIMER_CONTROL_OVERRUN_EN
    output logic         irq,
    output logic [7:0]   overrun
`else
    output logic         irq
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        CLEAR
    } state_t;

    state_t state;
    logic   mode;
    logic   hit;
    logic   fire;

    // Commands pre-empt a coincident expiry entirely.
    assign hit  = (state == RUN) && (cd.count == '0);
    assign fire = hit && !start && !stop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mode     <= 1'b0;
            cd.value <= '0;
            cd.put   <= 1'b0;
            running  <= 1'b0;
            expired  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            expired <= fire;
            if (fire) begin
                irq <= 1'b1;
            end else if (ack) begin
                irq <= 1'b0;
            end
            cd.put <= 1'b0;
            if (stop) begin
                state    <= CLEAR;
                cd.value <= '0;
                cd.put   <= 1'b1;
                running  <= 1'b0;
            end else if (start || (fire && mode)) begin
                state    <= LOAD;
                cd.value <= reload;
                mode     <= periodic;
                cd.put   <= 1'b1;
                running  <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                    LOAD: begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    RUN: begin
                        if (hit) begin
                            state   <= IDLE;
                            running <= 1'b0;
                        end
                    end
                    CLEAR: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef TIMER_CONTROL_OVERRUN_EN
    // Counts expiries that land on an interrupt still pending.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun <= '0;
        end else if (ack) begin
            overrun <= '0;
        end else if (fire && irq && (overrun != 8'hff)) begin
            overrun <= overrun + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_timer_control.sv
// Scoreboard bench for timer_control with a behavioural countdown.
// Expected put/expiry events are queued at stimulus time.
module tb_timer_control;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] reload = '0;
    logic       periodic = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       ack = 1'b0;
    logic       running;
    logic       expired;
    logic       irq;
`ifdef TIMER_CONTROL_OVERRUN_EN
    logic [7:0] overrun;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int putc_q[$];
    int putv_q[$];
    int exp_q[$];

    timer_control_if #(.W(8)) cd ();

    timer_control #(.W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .reload   (reload),
        .periodic (periodic),
        .start    (start),
        .stop     (stop),
        .ack      (ack),
        .cd       (cd.master),
        .running  (running),
        .expired  (expired),
`ifdef TIMER_CONTROL_OVERRUN_EN
        .irq      (irq),
        .overrun  (overrun)
`else
        .irq      (irq)
`endif
    );

    always #5 clock = ~clock;

    // Countdown stage: load on put, else decrement to zero and hold.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (cd.put) begin
            cd.count <= cd.value;
        end else if (cd.count != 8'd0) begin
            cd.count <= cd.count - 8'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (cd.put) begin
                if (putc_q.size() == 0) begin
                    chk("put_extra", cyc, 32'hffff_ffff);
                end else begin
                    chk("put_cyc", cyc, putc_q.pop_front());
                    chk("put_val", {24'd0, cd.value}, putv_q.pop_front());
                end
            end
            if (expired) begin
                if (exp_q.size() == 0) begin
                    chk("exp_extra", cyc, 32'hffff_ffff);
                end else begin
                    chk("exp_cyc", cyc, exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_to(input int c);
        int n = 0;
        while (cyc < c && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (cyc != c) chk("wait_to", cyc, c);
    endtask

    task automatic push_put(input int c, input int v);
        putc_q.push_back(c);
        putv_q.push_back(v);
    endtask

    task automatic launch(input logic [7:0] r, input logic p, output int l);
        reload = r;
        periodic = p;
        start = 1'b1;
        l = cyc + 1;
        push_put(l, r);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic clear_irq();
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        chk("irq_ack", irq, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_put"}, cd.put, 1'b0);
        chk({tag, "_val"}, cd.value, 8'd0);
        chk({tag, "_run"}, running, 1'b0);
        chk({tag, "_exp"}, expired, 1'b0);
        chk({tag, "_irq"}, irq, 1'b0);
`ifdef TIMER_CONTROL_OVERRUN_EN
        chk({tag, "_ovr"}, overrun, 8'd0);
`endif
    endtask

    initial begin
        int l;
        int l2;
        cd.count = 8'd0;
        repeat (3) @(negedge clock);
        chk_zero("rst");
        reset = 1'b1;
        @(negedge clock);

        // One-shot, reload 5
        launch(8'd5, 1'b0, l);
        exp_q.push_back(l + 7);
        wait_to(l + 3);
        chk("os_run", running, 1'b1);
        wait_to(l + 7);
        chk("os_irq", irq, 1'b1);
        wait_to(l + 8);
        chk("os_idle", running, 1'b0);
        wait_to(l + 12);
        clear_irq();

        // Periodic, reload 3: four periods then stop
        launch(8'd3, 1'b1, l);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(l + 5 * i);
            push_put(l + 5 * i, 3);
        end
        wait_to(l + 7);
        ack = 1'b1;
        wait_to(l + 8);
        ack = 1'b0;
        chk("per_ack", irq, 1'b0);
        wait_to(l + 10);
        chk("per_irq", irq, 1'b1);
        wait_to(l + 21);
        stop = 1'b1;
        push_put(l + 22, 0);
        wait_to(l + 22);
        stop = 1'b0;
        chk("per_stop", running, 1'b0);
        wait_to(l + 28);
        chk("per_cnt", cd.count, 8'd0);
        chk("per_irqh", irq, 1'b1);
        clear_irq();

        // Reload 0 periodic; ack meets expiry; stop eats expiry
        launch(8'd0, 1'b1, l);
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(l + 2 * i);
            push_put(l + 2 * i, 0);
        end
        wait_to(l + 5);
        ack = 1'b1;
        wait_to(l + 6);
        ack = 1'b0;
        chk("z_ackset", irq, 1'b1);
        wait_to(l + 7);
        stop = 1'b1;
        push_put(l + 8, 0);
        wait_to(l + 8);
        stop = 1'b0;
        wait_to(l + 12);
        chk("z_idle", running, 1'b0);
        clear_irq();

        // Stop in RUN with count 2
        launch(8'd5, 1'b0, l);
        wait_to(l + 4);
        chk("s_cnt", cd.count, 8'd2);
        stop = 1'b1;
        push_put(l + 5, 0);
        wait_to(l + 5);
        stop = 1'b0;
        chk("s_run", running, 1'b0);
        wait_to(l + 14);
        chk("s_irq", irq, 1'b0);
        chk("s_cnt0", cd.count, 8'd0);

        // Start and stop together: clear only
        reload = 8'd9;
        start = 1'b1;
        stop = 1'b1;
        push_put(cyc + 1, 0);
        @(negedge clock);
        start = 1'b0;
        stop = 1'b0;
        chk("ss_run", running, 1'b0);
        repeat (4) @(negedge clock);
        chk("ss_idle", running, 1'b0);

        // Restart on the expiry edge discards that expiry
        launch(8'd2, 1'b0, l);
        wait_to(l + 3);
        launch(8'd1, 1'b0, l2);
        chk("rs_l2", l2, l + 4);
        exp_q.push_back(l2 + 3);
        wait_to(l + 4);
        chk("rs_noirq", irq, 1'b0);
        wait_to(l2 + 6);
        chk("rs_irq", irq, 1'b1);
        chk("rs_idle", running, 1'b0);
        clear_irq();

`ifdef TIMER_CONTROL_OVERRUN_EN
        launch(8'd1, 1'b1, l);
        for (int i = 1; i <= 300; i++) begin
            exp_q.push_back(l + 3 * i);
            push_put(l + 3 * i, 1);
        end
        wait_to(l + 31);
        chk("ovr_9", overrun, 8'd9);
        wait_to(l + 901);
        stop = 1'b1;
        push_put(l + 902, 0);
        wait_to(l + 902);
        stop = 1'b0;
        chk("ovr_sat", overrun, 8'd255);
        clear_irq();
        chk("ovr_clr", overrun, 8'd0);
`endif

        // Reset asserted while put is high in periodic reload
        launch(8'd3, 1'b1, l);
        exp_q.push_back(l + 5);
        push_put(l + 5, 3);
        wait_to(l + 5);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("mid");
        @(negedge clock);
        #2;
        reset = 1'b1;
        repeat (8) @(negedge clock);
        chk("mid_idle", running, 1'b0);

        chk("putq_left", putc_q.size(), 0);
        chk("expq_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_control.md
Name: timer_control

Overview:
- Control stage wrapped around the countdown timer.
- Drives the countdown's `value`/`put` load interface and watches its `count` output.
- Provides one-shot and periodic modes, start/stop commands, a one-cycle expiry pulse and a sticky interrupt with acknowledge.
- Sits between the register/bus side and the countdown instance.

Parameters:
- W, 8, width of reload value and countdown count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- reload  in  W  period value, sampled at every load.
- periodic  in  1  1 = auto-reload on expiry, 0 = one-shot; sampled at every load.
- start  in  1  start/restart command, single-cycle.
- stop  in  1  abort command, single-cycle.
- ack  in  1  clears irq.
- count  in  W  current count from the countdown stage.
- value  out  W  load value to the countdown stage.
- put  out  1  load strobe to the countdown stage.
- running  out  1  high in LOAD and RUN.
- expired  out  1  one-cycle pulse on each expiry.
- irq  out  1  sticky interrupt pending.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; value=0, put=0, running=0, expired=0, irq=0, internal mode=0.
- All outputs are registered.
- States: IDLE, LOAD, RUN, CLEAR.
- Load action, taken on one edge:
  - value<=reload, mode<=periodic, put<=1, state<=LOAD.
  - The countdown captures value on the following edge.
- IDLE:
  - start: load action.
  - stop: CLEAR.
  - otherwise hold.
- LOAD (exactly one cycle, put=1): put<=0, state<=RUN. Countdown now holds the loaded value.
- RUN:
  - count==0 is an expiry: expired<=1 for one cycle and irq<=1.
  - Periodic mode: load action is taken in the same edge.
  - One-shot mode: state<=IDLE.
- Period in periodic mode is reload+2 clocks: count sequence N..1,0,0,N (last 0 held during the put cycle).
- One-shot: expired pulses reload+1 cycles after LOAD ends.
- reload==0: expiry on the first RUN cycle. Periodic mode then yields an expiry every 2 cycles.
- CLEAR (one cycle): value<=0, put<=1, then state<=IDLE with put<=0. This forces the countdown to 0. No expiry is generated.
- Priority when commands collide (any state): stop > start > expiry.
  - start in LOAD/RUN restarts with the new reload; a coincident expiry is discarded (no expired, no irq).
  - stop in any state goes to CLEAR; a coincident expiry is discarded.
- irq:
  - Set on expiry; cleared by ack.
  - Expiry and ack in the same cycle: irq stays 1 (set wins).
- expired is 0 in every cycle without an expiry.
- running=1 in LOAD and RUN, 0 otherwise.
- reset asserted mid-operation: immediate return to reset values. The countdown stage is not reset by this block.

Optional Feature:
- Macro: TIMER_CONTROL_OVERRUN_EN.
- When defined:
  - Adds output `overrun` (8 bits), reset 0.
  - Increments on every expiry that occurs while irq is already 1 and ack is 0; saturates at 255.
  - Cleared to 0 by ack (ack wins over a coincident increment).
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset low mid-RUN with put=1 -> all outputs 0 immediately; after release, state IDLE with no put.
- One-shot: reload=5, periodic=0, start -> put high 1 cycle with value=5; expired pulses once, 6 cycles after put falls; irq=1; running=0 afterwards; no further put.
- Periodic: reload=3, periodic=1, start -> expired pulses every 5 clocks over 4 periods; put reasserted with value=3 on each expiry edge; irq stays 1 until ack, clears the cycle after.
- reload=0, periodic=1 -> expired every 2 cycles. Then ack coinciding with expiry -> irq remains 1.
- stop during RUN with count=2 -> one put with value=0, running falls, no expired pulse. start and stop in the same cycle -> CLEAR path only.
- With TIMER_CONTROL_OVERRUN_EN: reload=1 periodic, no ack for 300 expiries -> overrun=255. Then ack -> overrun=0, irq=0.
